// File: rtl/rps_pkg.sv
// Shared types and default parameters for the rock/paper/scissors stream classifier.
package rps_pkg;

    typedef enum logic [1:0] {
        CLS_ROCK     = 2'd0,
        CLS_PAPER    = 2'd1,
        CLS_SCISSORS = 2'd2,
        CLS_EMPTY    = 2'd3
    } class_e;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    localparam int DEF_LENGTH         = 32;
    localparam int DEF_WIDTH          = 32;
    localparam int DEF_LEFT           = 16;
    localparam int DEF_SHIFT          = 4;
    localparam int DEF_LEFT_THRESH    = 200;
    localparam int DEF_TRANS_SCISSORS = 4;

endpackage

// File: rtl/rps_frame_buffer.sv
// LENGTH x WIDTH frame store: one synchronous write port, one combinational read port, no reset.
module rps_frame_buffer #(
    parameter int LENGTH = 32,
    parameter int WIDTH  = 32,
    localparam int AW    = $clog2(LENGTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [LENGTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rps_stream_classifier.sv
// Buffers a binary hand frame row by row, rescans it for edge transitions and emits a class.
// Build option CLASSIFIER_STATS_EN exposes the live accumulators on the stat_* ports.
module rps_stream_classifier
    import rps_pkg::*;
#(
    parameter int LENGTH         = DEF_LENGTH,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int LEFT           = DEF_LEFT,
    parameter int SHIFT          = DEF_SHIFT,
    parameter int LEFT_THRESH    = DEF_LEFT_THRESH,
    parameter int TRANS_SCISSORS = DEF_TRANS_SCISSORS,
    localparam int SUMW          = $clog2(LENGTH*WIDTH+1),
    localparam int LMW           = $clog2(WIDTH+1),
    localparam int TRW           = $clog2(LENGTH-1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             row_valid,
    output logic             row_ready,
    input  logic [WIDTH-1:0] row_data,
    output logic             res_valid,
    input  logic             res_ready,
    output class_e           res_class
`ifdef CLASSIFIER_STATS_EN
    ,
    output logic [SUMW-1:0]  stat_sum,
    output logic [SUMW-1:0]  stat_sum_left,
    output logic [LMW-1:0]   stat_leftmost,
    output logic [TRW-1:0]   stat_trans
`endif
);

    localparam int AW = $clog2(LENGTH);
    localparam int CW = $clog2(WIDTH+SHIFT+1);

    state_e           r_state;
    logic             r_row_ready;
    logic             r_res_valid;
    class_e           r_res_class;
    logic [AW-1:0]    r_row_cnt;
    logic [AW-1:0]    r_scan_idx;
    logic [SUMW-1:0]  r_sum_left;
    logic [LMW-1:0]   r_leftmost;
    logic [TRW-1:0]   r_trans;

    logic             w_accept;
    logic [SUMW-1:0]  w_pop_left;
    logic [LMW-1:0]   w_low;
    logic [WIDTH-1:0] w_rd_row;
    logic [CW-1:0]    w_col_b;
    logic [WIDTH-1:0] w_sh_a;
    logic [WIDTH-1:0] w_sh_b;
    logic             w_differ;
    logic             w_no_pixels;
    class_e           w_class;

    assign w_accept = (r_state == ST_LOAD) && row_valid && r_row_ready;

    rps_frame_buffer #(
        .LENGTH (LENGTH),
        .WIDTH  (WIDTH)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_row_cnt),
        .i_wdata (row_data),
        .i_raddr (r_scan_idx),
        .o_rdata (w_rd_row)
    );

    // w_low is WIDTH for an all-zero row, so the min() below leaves leftmost untouched.
    always_comb begin
        w_pop_left = '0;
        w_low      = LMW'(WIDTH);
        for (int j = 0; j < LEFT; j++) w_pop_left = w_pop_left + SUMW'(row_data[j]);
        for (int j = WIDTH-1; j >= 0; j--) begin
            if (row_data[j]) w_low = LMW'(j);
        end
    end

    // Right shifts make any column at or beyond WIDTH read as zero.
    assign w_col_b     = CW'(r_leftmost) + CW'(SHIFT);
    assign w_sh_a      = w_rd_row >> r_leftmost;
    assign w_sh_b      = w_rd_row >> w_col_b;
    assign w_no_pixels = (r_leftmost == LMW'(WIDTH));
    assign w_differ    = !w_no_pixels && (w_sh_a[0] != w_sh_b[0]);

    always_comb begin
        w_class = CLS_ROCK;
        if (w_no_pixels)                             w_class = CLS_EMPTY;
        else if (r_trans == TRW'(TRANS_SCISSORS))    w_class = CLS_SCISSORS;
        else if (int'(r_sum_left) > LEFT_THRESH)     w_class = CLS_PAPER;
    end

    // SCAN runs one extra cycle at idx LENGTH-2 so the class sees the final trans count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_LOAD;
            r_row_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_class <= CLS_ROCK;
            r_row_cnt   <= '0;
            r_scan_idx  <= '0;
            r_sum_left  <= '0;
            r_leftmost  <= LMW'(WIDTH);
            r_trans     <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_sum_left <= r_sum_left + w_pop_left;
                        if (w_low < r_leftmost) r_leftmost <= w_low;
                        if (r_row_cnt == AW'(LENGTH-1)) begin
                            r_row_cnt   <= '0;
                            r_scan_idx  <= '0;
                            r_trans     <= '0;
                            r_row_ready <= 1'b0;
                            r_state     <= ST_SCAN;
                        end else begin
                            r_row_cnt <= r_row_cnt + 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (r_scan_idx == AW'(LENGTH-2)) begin
                        r_res_class <= w_class;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_RESULT;
                    end else begin
                        if (w_differ) r_trans <= r_trans + 1'b1;
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_row_ready <= 1'b1;
                        r_sum_left  <= '0;
                        r_leftmost  <= LMW'(WIDTH);
                        r_trans     <= '0;
                        r_scan_idx  <= '0;
                        r_state     <= ST_LOAD;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

`ifdef CLASSIFIER_STATS_EN
    logic [SUMW-1:0] r_sum;
    logic [SUMW-1:0] w_pop;

    always_comb begin
        w_pop = '0;
        for (int j = 0; j < WIDTH; j++) w_pop = w_pop + SUMW'(row_data[j]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    r_sum <= '0;
        else if (w_accept)                          r_sum <= r_sum + w_pop;
        else if (r_state == ST_RESULT && res_ready) r_sum <= '0;
    end

    assign stat_sum      = r_sum;
    assign stat_sum_left = r_sum_left;
    assign stat_leftmost = r_leftmost;
    assign stat_trans    = r_trans;
`endif

    assign row_ready = r_row_ready;
    assign res_valid = r_res_valid;
    assign res_class = r_res_class;

endmodule

// File: tb/tb_rps_stream_classifier.sv
// Directed bench for rps_stream_classifier at default parameters (32x32 frames).
module tb_rps_stream_classifier;
    import rps_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        row_valid;
    logic        row_ready;
    logic [31:0] row_data;
    logic        res_valid;
    logic        res_ready;
    class_e      res_class;
`ifdef CLASSIFIER_STATS_EN
    logic [10:0] stat_sum;
    logic [10:0] stat_sum_left;
    logic [5:0]  stat_leftmost;
    logic [4:0]  stat_trans;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] frame [32];

    always #5 clk = ~clk;

    rps_stream_classifier dut (
        .clk       (clk),
        .rst       (rst),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_class (res_class)
`ifdef CLASSIFIER_STATS_EN
        ,
        .stat_sum      (stat_sum),
        .stat_sum_left (stat_sum_left),
        .stat_leftmost (stat_leftmost),
        .stat_trans    (stat_trans)
`endif
    );

    // Sends rows 0..nrows-1 of frame; ok=0 if row_ready never appears.
    task automatic send_rows(input int nrows, output bit ok);
        ok = 1'b1;
        for (int r = 0; r < nrows; r++) begin
            int to;
            @(negedge clk);
            row_valid = 1'b1;
            row_data  = frame[r];
            to = 0;
            while (!row_ready && to < 100) begin
                @(negedge clk);
                to++;
            end
            if (!row_ready) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        row_valid = 1'b0;
    endtask

    // Counts cycles from the last-row edge until res_valid; garbage rows are offered meanwhile.
    task automatic wait_result(output int cyc);
        cyc = 0;
        row_valid = 1'b1;
        row_data  = 32'hFFFF_FFFF;
        while (!res_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        row_valid = 1'b0;
        row_data  = '0;
    endtask

    task automatic accept_result;
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic run_frame(input string name, input class_e exp_cls,
                             input int e_sum, input int e_left, input int e_lm, input int e_tr);
        bit ok;
        int cyc;
        send_rows(32, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL %s row_ready: stalled, required accepted", name); end
        wait_result(cyc);
        total++;
        if (cyc !== 31) begin bad++; $display("FAIL %s latency: got %0d required 31", name, cyc); end
        total++;
        if (res_class !== exp_cls) begin bad++; $display("FAIL %s class: got %0d required %0d", name, res_class, exp_cls); end
        total++;
        if (row_ready !== 1'b0) begin bad++; $display("FAIL %s row_ready_in_result: got %b required 0", name, row_ready); end
`ifdef CLASSIFIER_STATS_EN
        total++;
        if (stat_sum !== 11'(e_sum)) begin bad++; $display("FAIL %s stat_sum: got %0d required %0d", name, stat_sum, e_sum); end
        total++;
        if (stat_sum_left !== 11'(e_left)) begin bad++; $display("FAIL %s stat_sum_left: got %0d required %0d", name, stat_sum_left, e_left); end
        total++;
        if (stat_leftmost !== 6'(e_lm)) begin bad++; $display("FAIL %s stat_leftmost: got %0d required %0d", name, stat_leftmost, e_lm); end
        total++;
        if (stat_trans !== 5'(e_tr)) begin bad++; $display("FAIL %s stat_trans: got %0d required %0d", name, stat_trans, e_tr); end
`else
        if (e_sum + e_left + e_lm + e_tr < 0) $display("unexpected stats args");
`endif
    endtask

    task automatic test_accept(input string name);
        accept_result();
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL %s res_valid_after_accept: got %b required 0", name, res_valid); end
        total++;
        if (row_ready !== 1'b1) begin bad++; $display("FAIL %s row_ready_after_accept: got %b required 1", name, row_ready); end
    endtask

    task automatic test_reset;
        total++;
        if (row_ready !== 1'b1) begin bad++; $display("FAIL reset row_ready: got %b required 1", row_ready); end
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL reset res_valid: got %b required 0", res_valid); end
        total++;
        if (res_class !== CLS_ROCK) begin bad++; $display("FAIL reset res_class: got %0d required 0", res_class); end
    endtask

    task automatic test_empty;
        for (int r = 0; r < 32; r++) frame[r] = '0;
        run_frame("empty", CLS_EMPTY, 0, 0, 32, 0);
        test_accept("empty");
    endtask

    task automatic test_paper;
        for (int r = 0; r < 32; r++) frame[r] = 32'h0000_FFFF;
        run_frame("paper", CLS_PAPER, 512, 512, 0, 0);
        test_accept("paper");
    endtask

    task automatic test_scissors;
        for (int r = 0; r < 32; r++) frame[r] = (r == 0 || r == 1 || r == 4 || r == 5) ? 32'h4 : 32'h0;
        run_frame("scissors", CLS_SCISSORS, 4, 4, 2, 4);
        test_accept("scissors");
    endtask

    task automatic test_rock_edge;
        for (int r = 0; r < 32; r++) frame[r] = (r < 30) ? 32'h4000_0000 : 32'h0;
        run_frame("rock_edge", CLS_ROCK, 30, 0, 30, 30);
        test_accept("rock_edge");
    endtask

    task automatic test_backpressure;
        for (int r = 0; r < 32; r++) frame[r] = 32'h0000_FFFF;
        run_frame("bp", CLS_PAPER, 512, 512, 0, 0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (res_valid !== 1'b1 || res_class !== CLS_PAPER || row_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: valid=%b class=%0d ready=%b required 1/1/0", c, res_valid, res_class, row_ready);
            end
        end
        test_accept("bp");
        for (int r = 0; r < 32; r++) frame[r] = (r == 0 || r == 1 || r == 4 || r == 5) ? 32'h4 : 32'h0;
        run_frame("bp_next", CLS_SCISSORS, 4, 4, 2, 4);
        test_accept("bp_next");
    endtask

    task automatic test_mid_reset;
        bit ok;
        for (int r = 0; r < 32; r++) frame[r] = 32'h0000_FFFF;
        send_rows(10, ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) frame[r] = '0;
        run_frame("after_rst", CLS_EMPTY, 0, 0, 32, 0);
        test_accept("after_rst");
    endtask

    initial begin
        rst       = 1'b1;
        row_valid = 1'b0;
        row_data  = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_empty();
        test_paper();
        test_scissors();
        test_rock_edge();
        test_backpressure();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rps_stream_classifier.md
Name: rps_stream_classifier

Overview:
Sequential, parametrised rock/paper/scissors classifier for binary hand images.
- Accepts a frame one row per cycle over a valid/ready handshake and buffers it.
- Accumulates pixel statistics while loading, then rescans the buffered frame to count edge transitions.
- Emits a class code on a held valid/ready result port. Sits between the camera binariser and the game-logic FSM.

Parameters:
LENGTH, 32, rows per frame (>=3)
WIDTH, 32, pixels per row (>=2)
LEFT, 16, columns 0..LEFT-1 form the left region (1..WIDTH)
SHIFT, 4, column offset used for transition compare (>=1)
LEFT_THRESH, 200, paper when sum_left > LEFT_THRESH
TRANS_SCISSORS, 4, scissors when transitions == TRANS_SCISSORS

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
row_valid  in  1  row data valid
row_ready  out  1  block accepts a row
row_data  in  WIDTH  one image row, bit j = column j
res_valid  out  1  result valid, held until accepted
res_ready  in  1  consumer accepts result
res_class  out  2  rps_pkg::class_e
stat_sum  out  SUMW  total set pixels (CLASSIFIER_STATS_EN only)
stat_sum_left  out  SUMW  left-region set pixels (CLASSIFIER_STATS_EN only)
stat_leftmost  out  LMW  leftmost set column, WIDTH if none (CLASSIFIER_STATS_EN only)
stat_trans  out  TRW  transition count (CLASSIFIER_STATS_EN only)

Widths:
- SUMW = $clog2(LENGTH*WIDTH+1)
- LMW = $clog2(WIDTH+1)
- TRW = $clog2(LENGTH-1)

Behaviour:
- FSM states: LOAD, SCAN, RESULT. Reset -> LOAD with row_ready=1, res_valid=0, res_class=CLS_ROCK, row counter 0, sum 0, sum_left 0, leftmost=WIDTH, trans 0.
- LOAD:
  - row_ready=1. On row_valid&&row_ready: write the row to buffer[row_cnt].
  - Update sums: sum += popcount(row); sum_left += popcount(row[LEFT-1:0]).
  - Update leftmost: leftmost = min(leftmost, lowest set bit of row). An all-zero row leaves leftmost unchanged.
  - Accepting row LENGTH-1 -> SCAN; scan index 0, trans 0.
- SCAN:
  - row_ready=0. One row per cycle, i = 0..LENGTH-3 (LENGTH-2 cycles).
  - Each cycle compare buffer[i][leftmost] with buffer[i][leftmost+SHIFT]; trans++ if they differ.
  - A column index >= WIDTH reads as 0.
  - If leftmost==WIDTH, no increments occur.
  - After index LENGTH-3 -> RESULT.
- RESULT:
  - res_valid=1. res_class is registered on entry and stable while waiting.
  - Priority: leftmost==WIDTH -> CLS_EMPTY; else trans==TRANS_SCISSORS -> CLS_SCISSORS; else sum_left>LEFT_THRESH -> CLS_PAPER; else CLS_ROCK.
  - On res_ready: res_valid drops next cycle, accumulators clear, -> LOAD. row_ready stays 0 until LOAD is re-entered; no row overlap.
- Latency: last row accepted at edge t; res_valid is high from edge t+LENGTH-1.
- Arithmetic: all counters saturate-free; widths are sized so overflow is impossible.
- row_valid in SCAN/RESULT is ignored; data must be held by the producer.
- rst asserted mid-frame or mid-scan: immediate return to reset state; the partial frame is discarded. Buffer contents need not be cleared.

Optional Feature:
CLASSIFIER_STATS_EN
- Defined: the four stat_* ports exist and show the live accumulator values. They are frozen and valid while res_valid=1.
- Undefined: the stat_* ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rps_pkg:
  - class_e enum: CLS_ROCK=0, CLS_PAPER=1, CLS_SCISSORS=2, CLS_EMPTY=3.
  - state_e enum.
  - Default LENGTH/WIDTH/LEFT/SHIFT/threshold constants.
- Sub-module rps_frame_buffer: LENGTH x WIDTH register array, one synchronous write port, one combinational read port, no reset on storage.

Test Plan:
- All-zero 32x32 frame -> CLS_EMPTY; stat_sum=0, stat_leftmost=32, stat_trans=0; res_valid at cycle 31 after last row.
- Columns 0..15 set in all 32 rows -> stat_sum=512, stat_sum_left=512, leftmost=0. Column 4 is also set, so trans=0 -> CLS_PAPER.
- Only column 2 set in rows 0,1,4,5, all else 0, SHIFT=4 -> leftmost=2, trans=4 -> CLS_SCISSORS with sum_left=4.
- Only column 30 set in rows 0..29 -> compare against column 34 (reads 0): trans=30, sum_left=0 -> CLS_ROCK.
- Backpressure: hold res_ready=0 for 10 cycles -> res_valid and res_class stable, row_ready=0. Raising res_ready -> LOAD next cycle and the next frame classifies independently.
- Assert rst after 10 rows of a paper frame, then send a full empty frame -> CLS_EMPTY with stat_sum=0.
